l1ci_mem_responder: RTL and testbench
=====================================

Name: l1ci_mem_responder

Overview:
- Memory-side responder for the L1 instruction/data cache miss interface (I_req/I_addr/I_write/I_in/I_type -> I_out/I_wait).
- Serves 4-word line fills as wait-gated beats and performs single-word byte-masked writes into an internal word-addressed backing store.
- Used as the cache's memory model in block-level benches. Also used as the local store behind the CPU wrapper when AXI is bypassed.

Parameters:
- DEPTH_WORDS, 1024: backing store size in 32-bit words; must be a power of 2.
- RD_LATENCY, 2: idle cycles between request acceptance and the first read beat (0 legal).
- BEAT_GAP, 0: idle cycles between consecutive read beats.
- WR_LATENCY, 1: idle cycles between write acceptance and write completion (0 legal).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- I_req  in  1  request from cache; sampled only in IDLE.
- I_addr  in  32  byte address.
- I_write  in  1  1 = write, 0 = line read.
- I_in  in  32  write data, already byte-lane aligned.
- I_type  in  3  access size: BYTE 000, HWORD 001, WORD 010, BYTE_U 100, HWORD_U 101.
- I_out  out  32  read beat data; valid only while I_wait=0 in a read.
- I_wait  out  1  0 marks a beat or completion cycle; 1 otherwise.
- init_we  in  1  bench preload write enable.
- init_addr  in  log2(DEPTH_WORDS)  preload word index.
- init_data  in  32  preload data.

Behaviour:
- Reset: state=IDLE, I_wait=1, I_out=0, beat=0, cnt=0. Backing store contents are not reset.
- Word index is (addr>>2) mod DEPTH_WORDS. Addresses wrap silently.
- IDLE:
  - I_wait=1.
  - I_req & ~I_write: latch base={I_addr[31:4],4'h0}, beat=0, cnt=RD_LATENCY; go to RD.
  - I_req & I_write: latch addr, I_in, and strobe; cnt=WR_LATENCY; go to WR.
- RD:
  - While cnt!=0: cnt--, I_wait=1.
  - When cnt==0: one beat cycle. I_wait=0, I_out=mem[base/4+beat].
    - beat<3: beat++, cnt=BEAT_GAP.
    - beat==3: go to IDLE.
  - Beats are always in order 0,1,2,3 from the line base; I_addr[3:0] is ignored.
  - First beat arrives RD_LATENCY+1 cycles after the acceptance edge.
  - With BEAT_GAP=0, the 4 beats occupy 4 consecutive cycles.
- WR:
  - While cnt!=0: cnt--, I_wait=1.
  - When cnt==0: commit byte-masked write, I_wait=0 for one cycle, go to IDLE.
  - Strobe encoding:
    - WORD: 4'hF.
    - HWORD/HWORD_U: 4'b0011<<{addr[1],1'b0}.
    - BYTE/BYTE_U: 4'b0001<<addr[1:0].
    - Any other I_type: 0. No store, but the completion cycle still occurs.
- I_out is registered and holds the last beat value outside beat cycles. It is not updated by writes.
- I_req, I_addr, and I_in changes after acceptance are ignored. A burst or write always completes once accepted, even if I_req drops.
- At least one IDLE cycle separates transactions. A request present on the cycle of return to IDLE is accepted on the next edge.
- init_we writes init_data at init_addr in any state.
  - Collision with a WR commit at the same index: commit wins.
  - A read beat in the same cycle returns the old data.
- rst mid-transaction: immediate return to IDLE, I_wait=1. A pending write is dropped with memory unchanged.

Test Plan:
- Line read: preload words 0x40..0x4C with 0xA0..0xA3; read req addr 0x48, RD_LATENCY=2 -> I_wait low on cycles 3,4,5,6 after acceptance with I_out 0xA0,0xA1,0xA2,0xA3, then I_wait=1.
- BEAT_GAP=1: same read -> beats on cycles 3,5,7,9; I_wait=1 and I_out held at 0xA0 on cycle 4.
- Byte write: word 0x100 = 0x11223344; write I_type=BYTE, addr 0x102, I_in=0x00AB0000 -> one I_wait=0 cycle; subsequent read returns 0x11AB3344. HWORD at 0x102 with I_in 0xBEEF0000 -> 0xBEEF3344.
- Req drop: I_req high one cycle only -> all 4 beats still delivered; no new transaction starts without a fresh I_req in IDLE.
- Reset mid-burst after beat 1 -> I_wait=1, I_out=0, state IDLE; next read starts again from beat 0.
- Wrap and collision: address DEPTH_WORDS*4+0x10 reads the same data as 0x10; init_we to the same index as a WR commit leaves the commit value.

Source files
------------

// File: rtl/l1ci_mem_responder.sv
// ---------------------------------------------------------------------------
// l1ci_mem_responder: memory-side responder for the L1 cache miss interface.
// Serves wait-gated 4-word line fills and byte-masked single-word writes.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module l1ci_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LATENCY  = 2,
  parameter int BEAT_GAP    = 0,
  parameter int WR_LATENCY  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           I_req,
  input  logic [31:0]                    I_addr,
  input  logic                           I_write,
  input  logic [31:0]                    I_in,
  input  logic [2:0]                     I_type,
  output logic [31:0]                    I_out,
  output logic                           I_wait,
  input  logic                           init_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] init_addr,
  input  logic [31:0]                    init_data
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int LW    = AW - 2;
  localparam int MAXL0 = (RD_LATENCY > BEAT_GAP) ? RD_LATENCY : BEAT_GAP;
  localparam int MAXL  = (MAXL0 > WR_LATENCY) ? MAXL0 : WR_LATENCY;
  localparam int CW    = (MAXL < 1) ? 1 : $clog2(MAXL + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t          state;
  logic [LW-1:0]   line;
  logic [1:0]      beat;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   wr_idx;
  logic [31:0]     wr_data;
  logic [3:0]      wr_strb;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [3:0]      strb;
  logic [AW-1:0]   rd_idx;
  logic [31:0]     rd_word;
  logic            commit;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^I_addr[31:AW+2];

  always_comb begin
    strb = 4'h0;
    case (I_type)
      3'b010:         strb = 4'hF;
      3'b001, 3'b101: strb = 4'b0011 << {I_addr[1], 1'b0};
      3'b000, 3'b100: strb = 4'b0001 << I_addr[1:0];
      default:        strb = 4'h0;
    endcase
  end

  // I_out is registered, so the beat word is fetched on the edge that enters
  // the beat cycle; init writes landing on that same edge are forwarded.
  always_comb begin
    rd_idx = {line, beat};
    if (state == IDLE)
      rd_idx = {I_addr[AW+1:4], 2'b00};
    else if (state == RD && cnt == '0)
      rd_idx = {line, beat + 2'd1};
  end

  assign rd_word = (init_we && init_addr == rd_idx) ? init_data : mem[rd_idx];
  assign commit  = (state == WR) && (cnt == '0);

  // Commit is applied after init so a same-index collision keeps the commit.
  always_ff @(posedge clk) begin
    if (init_we)
      mem[init_addr] <= init_data;
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b])
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      I_wait  <= 1'b1;
      I_out   <= 32'h0;
      beat    <= 2'd0;
      cnt     <= '0;
      line    <= '0;
      wr_idx  <= '0;
      wr_data <= 32'h0;
      wr_strb <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          I_wait <= 1'b1;
          if (I_req && !I_write) begin
            line  <= I_addr[AW+1:4];
            beat  <= 2'd0;
            cnt   <= CW'(RD_LATENCY);
            state <= RD;
            if (RD_LATENCY == 0) begin
              I_out  <= rd_word;
              I_wait <= 1'b0;
            end
          end else if (I_req && I_write) begin
            wr_idx  <= I_addr[AW+1:2];
            wr_data <= I_in;
            wr_strb <= strb;
            cnt     <= CW'(WR_LATENCY);
            state   <= WR;
            if (WR_LATENCY == 0)
              I_wait <= 1'b0;
          end
        end
        RD: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              I_out  <= rd_word;
              I_wait <= 1'b0;
            end else begin
              I_wait <= 1'b1;
            end
          end else if (beat != 2'd3) begin
            beat <= beat + 2'd1;
            cnt  <= CW'(BEAT_GAP);
            if (BEAT_GAP == 0) begin
              I_out  <= rd_word;
              I_wait <= 1'b0;
            end else begin
              I_wait <= 1'b1;
            end
          end else begin
            state  <= IDLE;
            I_wait <= 1'b1;
          end
        end
        WR: begin
          if (cnt != '0) begin
            cnt    <= cnt - CW'(1);
            I_wait <= (cnt != CW'(1));
          end else begin
            state  <= IDLE;
            I_wait <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          I_wait <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_l1ci_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_l1ci_mem_responder: directed + random bench for l1ci_mem_responder,
// two instances (beat gap 0 and 1) driven in parallel. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_l1ci_mem_responder;

  localparam int DEPTH = 1024;
  localparam int RL    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        I_req;
  logic [31:0] I_addr;
  logic        I_write;
  logic [31:0] I_in;
  logic [2:0]  I_type;
  logic        init_we;
  logic [9:0]  init_addr;
  logic [31:0] init_data;
  logic [31:0] out_a, out_b;
  logic        wait_a, wait_b;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] mem_m [DEPTH];
  logic [31:0] lo [2];

  always #5 clk = ~clk;

  l1ci_mem_responder #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(RL), .BEAT_GAP(0), .WR_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .I_req(I_req), .I_addr(I_addr), .I_write(I_write),
    .I_in(I_in), .I_type(I_type), .I_out(out_a), .I_wait(wait_a),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data));

  l1ci_mem_responder #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(RL), .BEAT_GAP(1), .WR_LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .I_req(I_req), .I_addr(I_addr), .I_write(I_write),
    .I_in(I_in), .I_type(I_type), .I_out(out_b), .I_wait(wait_b),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic wa, input logic wb);
    chk({tag, " A wait"}, {31'd0, wait_a}, {31'd0, wa});
    chk({tag, " A out"}, out_a, lo[0]);
    chk({tag, " B wait"}, {31'd0, wait_b}, {31'd0, wb});
    chk({tag, " B out"}, out_b, lo[1]);
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    @(negedge clk);
    init_we = 1'b1; init_addr = 10'(idx); init_data = data;
    @(posedge clk); #1;
    init_we = 1'b0;
    mem_m[idx] = data;
  endtask

  // Line read: beat i of the instance with gap g lands on cycle RL+1+i*(g+1)
  // after acceptance and shows the model word as of the start of that cycle.
  task automatic rd(input string name, input logic [31:0] addr, input int inj_c,
                    input int inj_idx, input logic [31:0] inj_data, input int abort_c);
    int  base;
    bit  bn [2];
    @(negedge clk);
    I_req = 1'b1; I_write = 1'b0; I_addr = addr;
    I_type = 3'($urandom); I_in = $urandom;
    @(posedge clk); #1;
    I_req = 1'b0; I_addr = $urandom; I_in = $urandom;
    base = int'((addr >> 2) & 32'h3FF) & ~3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        bn[d] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (c == RL + 1 + i * (d + 1)) begin
            bn[d] = 1'b1;
            lo[d] = mem_m[base + i];
          end
        end
      end
      chk_both($sformatf("%s c%0d", name, c), !bn[0], !bn[1]);
      if (c == abort_c) begin
        rst = 1'b1;
        #2;
        lo[0] = 32'h0; lo[1] = 32'h0;
        chk_both($sformatf("%s reset", name), 1'b1, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (c == inj_c) begin
        init_we = 1'b1; init_addr = 10'(inj_idx); init_data = inj_data;
        @(posedge clk); #1;
        init_we = 1'b0;
        mem_m[inj_idx] = inj_data;
      end
    end
  endtask

  task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data,
                    input logic [2:0] typ, input bit col, input logic [31:0] col_data);
    int idx, n, off;
    idx = int'((addr >> 2) & 32'h3FF);
    @(negedge clk);
    I_req = 1'b1; I_write = 1'b1; I_addr = addr; I_in = data; I_type = typ;
    @(posedge clk); #1;
    I_req = 1'b0; I_addr = $urandom; I_in = $urandom; I_type = 3'($urandom);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk_both($sformatf("%s c%0d", name, c), c != 2, c != 2);
      if (c == 2 && col) begin
        init_we = 1'b1; init_addr = 10'(idx); init_data = col_data;
        @(posedge clk); #1;
        init_we = 1'b0;
        mem_m[idx] = col_data;
      end
    end
    case (typ)
      3'd0, 3'd4: begin n = 1; off = int'(addr[1:0]); end
      3'd1, 3'd5: begin n = 2; off = addr[1] ? 2 : 0; end
      3'd2:       begin n = 4; off = 0; end
      default:    begin n = 0; off = 0; end
    endcase
    for (int k = off; k < off + n; k++)
      mem_m[idx][8*k +: 8] = data[8*k +: 8];
  endtask

  task automatic idle_chk(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk_both($sformatf("idle c%0d", c), 1'b1, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; I_req = 1'b0; I_addr = 32'h0; I_write = 1'b0; I_in = 32'h0;
    I_type = 3'd0; init_we = 1'b0; init_addr = 10'd0; init_data = 32'h0;
    lo[0] = 32'h0; lo[1] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_both("reset", 1'b1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 128; i++) preload(i, $urandom);
    for (int i = 0; i < 4; i++) preload(16 + i, 32'hA0 + 32'(i));
    preload(32'h40, 32'h11223344);

    rd("line", 32'h48, 0, 0, 0, 0);
    idle_chk(3);

    wr("wbyte", 32'h102, 32'h00AB0000, 3'b000, 1'b0, 0);
    rd("rbyte", 32'h100, 0, 0, 0, 0);
    chk("byte merge model", mem_m[32'h40], 32'h11AB3344);
    wr("whw", 32'h102, 32'hBEEF0000, 3'b001, 1'b0, 0);
    rd("rhw", 32'h100, 0, 0, 0, 0);

    rd("abort", 32'h40, 0, 0, 0, 4);
    rd("after_abort", 32'h40, 0, 0, 0, 0);

    rd("wrap", 32'(DEPTH * 4 + 32'h10), 0, 0, 0, 0);

    wr("wcol", 32'h20, 32'hCAFEF00D, 3'b010, 1'b1, 32'h12345678);
    rd("rcol", 32'h20, 0, 0, 0, 0);

    rd("beat_init", 32'h40, 4, 32'h11, 32'h5A5A5A5A, 0);
    rd("beat_init_after", 32'h44, 0, 0, 0, 0);

    wr("wbad", 32'h104, 32'hFFFFFFFF, 3'b011, 1'b0, 0);
    rd("rbad", 32'h100, 0, 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      a = $urandom & 32'hFFFF_F1FF;
      if ($urandom_range(0, 1) == 1)
        rd($sformatf("rnd%0d_rd", t), a, 0, 0, 0, 0);
      else
        wr($sformatf("rnd%0d_wr", t), a, $urandom, 3'($urandom_range(0, 7)), 1'b0, 0);
    end
    idle_chk(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
